fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage directly downstream of the program counter. Takes the
//  PC's imemaddr, issues instruction reads to the icache and buffers returned
//  words with their PC in a small queue. Presents {instr, pc, pc+4} to decode
//  with a valid/stall handshake. Generates pc_en, which drives the PC's ihit input.
// PARAMETERS
//  DEPTH   2   queue entries (power of 2, >=2)
// PORTS
//  CLK         in   1   system clock, rising edge
//  nRST        in   1   asynchronous active-low reset
//  pc_addr     in   32  word_t, current PC (from pc.imemaddr)
//  pc_en       out  1   PC advance strobe; drives pc.ihit
//  imemREN     out  1   icache read request
//  imemaddr    out  32  icache address (= pc_addr)
//  ihit        in   1   icache data valid this cycle
//  imemload    in   32  icache read data
//  flush       in   1   branch/jump redirect; next_pc already holds target
//  dec_stall   in   1   decode cannot accept this cycle
//  valid_o     out  1   queue head valid
//  instr_o     out  32  head instruction
//  pc_o        out  32  head PC
//  npc_o       out  32  head PC + 4
// BEHAVIOUR
//  Reset (nRST low, async): queue empty, count=0, rd/wr ptr=0, state=FETCH;
//   valid_o=0, pc_en=0, imemREN=0 while nRST low; instr_o/pc_o/npc_o=0.
//  pop  = valid_o & ~dec_stall & ~flush.
//  full = (count==DEPTH). imemREN = (state==FETCH) & (~full | pop) & ~flush.
//  imemaddr = pc_addr (combinational, always driven).
//  push = imemREN & ihit: writes {imemload, pc_addr} at wr ptr; pc_en=1 same cycle.
//  Push and pop in one cycle: count unchanged, both pointers advance; legal when full.
//  Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits, never over/underflows.
//  valid_o = (count!=0). Head fields are combinational from rd ptr (0 latency
//   from queue); fetch-to-decode latency = 1 cycle after ihit.
//  npc_o = pc_o + 4, 32-bit, wraps silently.
//  States: FETCH, HALTED.
//   FETCH  -> HALTED when a pushed word has opcode == HALT (6'h3F); that word
//            still enters the queue; no requests afterwards.
//   HALTED -> FETCH on flush (halt was on a wrong path).
//   HALTED holds; imemREN=0, pc_en=0; queue drains to decode normally.
//  flush (priority over everything): next edge clears queue (count=0, ptrs=0),
//   state=FETCH; pc_en=1 in the flush cycle so the PC loads the redirect
//   target; any ihit/imemload that cycle is discarded; no pop that cycle.
//  ihit with imemREN=0: ignored, no push, pc_en=0.
//  dec_stall with empty queue: no effect.
//  Reset mid-miss: request dropped immediately; fetch restarts at pc_addr after reset.
// STRUCTURE
//  Shared package (pipeline_types_pkg): fetch_state_t {FETCH, HALTED};
//   fetch_entry_t struct {word_t instr; word_t pc;}; HALT opcode from
//   cpu_types_pkg (opcode_t).
//  Sub-module fetch_queue: generic DEPTH-entry FIFO of fetch_entry_t with
//   push/pop/full/empty/flush; fetch_stage holds the FSM and handshake logic.
// TESTING
//  1 Reset, pc_addr=0, ihit=1 every cycle, no stall -> pc_en=1 each cycle;
//    valid_o=1 from cycle 2; pc_o=0,4,8; npc_o=4,8,12.
//  2 dec_stall=1 held 4 cycles, ihit=1 -> 2 pushes, then full: imemREN=0,
//    pc_en=0; release stall -> entries pop in order, no loss or duplicates.
//  3 Full queue, dec_stall=0, ihit=1 -> push+pop same cycle, count stays 2.
//  4 flush while 2 entries queued and ihit=1 -> pc_en=1 that cycle; next cycle
//    valid_o=0, count=0; next fetch uses new pc_addr (e.g. 0x40).
//  5 imemload=0xFC000000 pushed -> HALTED, imemREN=0; queue drains to decode;
//    flush -> FETCH, requests resume.
//  6 nRST low mid-miss (ihit=0 for 3 cycles) -> outputs 0 immediately;
//    after release, first pushed pc_o equals pc_addr.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage: machine word, fetch queue entry,
// fetch FSM states and the HALT opcode.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    localparam opcode_t OpHalt = 6'h3F;

    typedef enum logic [0:0] {
        StFetch,
        StHalted
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

    function automatic logic is_halt(word_t instr);
        return instr[31:26] == OpHalt;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: PC coupling, icache request/response and decode handshake.
// master = fetch stage, slave = surrounding pipeline/testbench.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    word_t pc_addr;
    logic  pc_en;
    logic  imem_ren;
    word_t imem_addr;
    logic  ihit;
    word_t imem_load;
    logic  flush;
    logic  dec_stall;
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;

    modport master (
        input  pc_addr, ihit, imem_load, flush, dec_stall,
        output pc_en, imem_ren, imem_addr, valid, instr, pc, npc
    );

    modport slave (
        output pc_addr, ihit, imem_load, flush, dec_stall,
        input  pc_en, imem_ren, imem_addr, valid, instr, pc, npc
    );

endinterface

// File: rtl/fetch_queue.sv
// Depth-entry FIFO of fetch entries with synchronous flush. Head is read
// combinationally; simultaneous push and pop is allowed even when full.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full queue is only accepted when a pop frees the slot.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop)      count_d = count_q + CntW'(1);
            else if (!do_push && do_pop) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: requests words at the PC address, queues them with
// their PC and hands {instr, pc, pc+4} to decode; stops fetching after a HALT.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fetch_stage_if.master bus
);

    fetch_state_t state_q;
    fetch_entry_t wr_entry, head;
    logic         full, empty;
    logic         pop, push, fetch_ok;

    assign pop      = ~empty & ~bus.dec_stall & ~bus.flush;
    // Gated by reset so no request escapes while the core is held in reset.
    assign fetch_ok = rst_ni & (state_q == StFetch) & (~full | pop) & ~bus.flush;
    assign push     = fetch_ok & bus.ihit;

    assign wr_entry.instr = bus.imem_load;
    assign wr_entry.pc    = bus.pc_addr;

    assign bus.imem_ren  = fetch_ok;
    assign bus.imem_addr = bus.pc_addr;
    assign bus.pc_en     = rst_ni & (push | bus.flush);
    assign bus.valid     = ~empty;
    assign bus.instr     = head.instr;
    assign bus.pc        = head.pc;
    assign bus.npc       = rst_ni ? (head.pc + 32'd4) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFetch;
        end else if (bus.flush) begin
            state_q <= StFetch;
        end else if (push && is_halt(bus.imem_load)) begin
            state_q <= StHalted;
        end
    end

    fetch_queue #(
        .Depth (Depth)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (bus.flush),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (wr_entry),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage: a predictor queues expected
// fetched words, a monitor checks them against what decode is shown.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int unsigned Depth = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_stage_if bus();

    fetch_stage #(
        .Depth (Depth)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    fetch_entry_t exp_q[$];
    bit           halted   = 1'b0;
    bit           pre_full = 1'b0;
    bit           pre_pop  = 1'b0;
    word_t        pc_model = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: checks what decode sees and consumes expected entries on a pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", {31'd0, bus.valid}, 32'd0);
            check("rst_instr", bus.instr, 32'd0);
            check("rst_pc", bus.pc, 32'd0);
            check("rst_npc", bus.npc, 32'd0);
            exp_q.delete();
            pre_full = 1'b0;
            pre_pop  = 1'b0;
        end else begin
            check("valid", {31'd0, bus.valid}, {31'd0, exp_q.size() != 0});
            pre_full = (exp_q.size() == Depth);
            pre_pop  = (exp_q.size() != 0) && !bus.dec_stall && !bus.flush;
            if (exp_q.size() != 0 && bus.valid) begin
                check("head_instr", bus.instr, exp_q[0].instr);
                check("head_pc", bus.pc, exp_q[0].pc);
                check("head_npc", bus.npc, exp_q[0].pc + 32'd4);
            end
            if (bus.flush) exp_q.delete();
            else if (pre_pop) void'(exp_q.pop_front());
        end
    end

    // Predictor: decides whether a fetch should be issued and queues the result.
    always @(negedge clk) begin
        bit           exp_ren;
        fetch_entry_t e;
        #1;
        if (!rst_n) begin
            halted = 1'b0;
            check("rst_ren", {31'd0, bus.imem_ren}, 32'd0);
            check("rst_pc_en", {31'd0, bus.pc_en}, 32'd0);
        end else begin
            exp_ren = !halted && (!pre_full || pre_pop) && !bus.flush;
            check("imem_ren", {31'd0, bus.imem_ren}, {31'd0, exp_ren});
            check("pc_en", {31'd0, bus.pc_en}, {31'd0, (exp_ren && bus.ihit) || bus.flush});
            check("imem_addr", bus.imem_addr, bus.pc_addr);
            if (bus.flush) begin
                halted = 1'b0;
            end else if (exp_ren && bus.ihit) begin
                e.instr = bus.imem_load;
                e.pc    = bus.pc_addr;
                exp_q.push_back(e);
                if (bus.imem_load[31:26] == 6'h3F) halted = 1'b1;
            end
        end
    end

    // Acts as the PC and icache: advance on pc_en, redirect on flush.
    task automatic run_phase(input int n, input int p_ihit, input int p_stall,
                             input int p_flush, input int p_halt);
        logic  en, fl;
        word_t tgt, w;
        tgt = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en  = bus.pc_en;
            fl  = bus.flush;
            @(posedge clk);
            #1;
            if (fl)      pc_model = tgt;
            else if (en) pc_model = pc_model + 32'd4;
            tgt           = {$urandom_range(0, 255), 2'b00};
            bus.ihit      = ($urandom_range(0, 99) < p_ihit);
            bus.dec_stall = ($urandom_range(0, 99) < p_stall);
            bus.flush     = ($urandom_range(0, 99) < p_flush);
            w             = $urandom;
            if ($urandom_range(0, 99) < p_halt) w[31:26] = 6'h3F;
            else if (w[31:26] == 6'h3F)         w[31] = 1'b0;
            bus.imem_load = w;
            bus.pc_addr   = pc_model;
        end
    endtask

    initial begin
        bus.pc_addr   = '0;
        bus.ihit      = 1'b0;
        bus.imem_load = '0;
        bus.flush     = 1'b0;
        bus.dec_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_phase(8, 100, 0, 0, 0);      // streaming from PC 0
        run_phase(6, 100, 100, 0, 0);    // decode stalled: queue fills
        run_phase(6, 100, 0, 0, 0);      // release: drain plus refill
        run_phase(20, 100, 0, 15, 0);    // redirects with a busy queue
        run_phase(400, 70, 40, 8, 5);    // general mix
        run_phase(200, 80, 30, 3, 15);   // frequent HALT words

        // Reset while the icache is missing
        run_phase(3, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_ren", {31'd0, bus.imem_ren}, 32'd0);
        check("async_rst_valid", {31'd0, bus.valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_phase(8, 100, 0, 0, 0);
        run_phase(8, 0, 0, 0, 0);        // drain

        @(negedge clk);
        check("final_empty", {31'd0, bus.valid}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
